hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 4, meaning the cycles from a 64-bit op issue to Hi/Lo commit (legal range 1..15).
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-004 MulStart  input  1  EX stage issues a 64-bit result (MULTU/MADD/MSUB/MUL) this cycle.
REQ-005 ALU64Result  input  64  64-bit ALU result to be committed to {Hi,Lo}.
REQ-006 MoveHi  input  1  MTHI: write MoveData to Hi.
REQ-007 MoveLo  input  1  MTLO: write MoveData to Lo.
REQ-008 MoveData  input  32  data for MTHI/MTLO.
REQ-009 ReadReq  input  1  decode holds an instruction that reads Hi/Lo (MFHI/MFLO/MADD/MSUB).
REQ-010 HiLo  output  64  registered {Hi[63:32],Lo[31:0]}, fed to the ALU HiLo input.
REQ-011 Busy  output  1  high while a 64-bit result is pending commit.
REQ-012 Stall  output  1  combinational; the pipeline SHALL hold the requesting instruction when this is high.

Function
REQ-013 The FSM SHALL have two states: IDLE and BUSY; it SHALL hold a 4-bit down-counter cnt and a 64-bit pending register.
REQ-014 In IDLE with MulStart=1, the edge SHALL capture pending<=ALU64Result and cnt<=MUL_LAT-1, and go to BUSY.
REQ-015 In BUSY with cnt!=0, the edge SHALL decrement cnt and leave HiLo unchanged.
REQ-016 In BUSY with cnt==0, the edge SHALL load HiLo<=pending and go to IDLE.
REQ-017 Commit latency SHALL be exactly MUL_LAT edges after the issue edge; with MUL_LAT=1, HiLo updates on the edge after issue.
REQ-018 Busy SHALL equal (state==BUSY).
REQ-019 Stall SHALL equal Busy & (MulStart | MoveHi | MoveLo | ReadReq).
REQ-020 Stall SHALL be low in IDLE regardless of inputs.
REQ-021 In BUSY, MulStart, MoveHi, MoveLo and ReadReq SHALL have no effect on state, including in the commit cycle; the stalled request SHALL be re-presented by upstream and taken in IDLE.
REQ-022 In IDLE with MulStart=0, MoveHi=1 SHALL load HiLo[63:32]<=MoveData on the edge.
REQ-023 In IDLE with MulStart=0, MoveLo=1 SHALL load HiLo[31:0]<=MoveData on the edge.
REQ-024 In IDLE with MulStart=0, if MoveHi and MoveLo are both high, both halves SHALL be written with MoveData.
REQ-025 In IDLE, MulStart SHALL take priority over MoveHi/MoveLo; moves in the same cycle SHALL be dropped.
REQ-026 ALU64Result SHALL be stored unmodified, with no sign or width adjustment; HiLo SHALL change only on a commit or an IDLE move.
REQ-027 Back-to-back MADDs SHALL be serialized by Stall, so each MADD reads the committed HiLo of the previous one.

Reset
REQ-028 Reset=1 SHALL force the next state to IDLE, set HiLo=0, pending=0 and cnt=0, and set Busy=0 and Stall=0, overriding all other inputs.
REQ-029 Reset asserted in BUSY SHALL discard the pending result; no commit SHALL occur after reset.
REQ-030 After Reset deasserts, the first edge with MulStart=1 SHALL be accepted normally.

Verification
REQ-031 Reset, then MulStart=1 with ALU64Result=64'h0000_0001_FFFF_FFFE and MUL_LAT=4 -> Busy high for 4 cycles, HiLo=64'h0000_0001_FFFF_FFFE after the 4th edge, Busy low.
REQ-032 Issue a multiply, then hold ReadReq=1 during BUSY -> Stall=1 every BUSY cycle, Stall=0 in the first IDLE cycle, HiLo already holds the new value.
REQ-033 In IDLE, MoveHi=1 with MoveData=32'hDEAD_BEEF, then MoveLo=1 with MoveData=32'h1234_5678 -> HiLo=64'hDEAD_BEEF_1234_5678.
REQ-034 In IDLE, MulStart=1 (ALU64Result=64'h5) with MoveLo=1 (MoveData=32'h9) in the same cycle -> MoveLo dropped, HiLo=64'h5 after MUL_LAT edges.
REQ-035 Issue a multiply with ALU64Result=64'hAAAA, assert Reset at cnt=2 -> HiLo=0 and Busy=0 on the next edge, and HiLo stays 0 for the following 5 cycles.
REQ-036 MUL_LAT=1, two consecutive MulStarts (values 64'h1, then 64'h2) -> second is stalled one cycle, HiLo=1 and then HiLo=2 on successive commits.

Source files
------------

// File: rtl/hilo_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_unit_if
// Bundles the signals between the EX/decode stages and the Hi/Lo register unit.
//   MulStart     : EX issues a 64-bit result this cycle
//   ALU64Result  : 64-bit value to commit to {Hi,Lo}
//   MoveHi/Lo    : MTHI / MTLO write strobes
//   MoveData     : 32-bit data for MTHI / MTLO
//   ReadReq      : decode holds an instruction that reads Hi/Lo
//   HiLo         : registered {Hi,Lo}
//   Busy         : a 64-bit result is pending commit
//   Stall        : hold the requesting instruction
// master = pipeline side, slave = hilo_unit.
// -----------------------------------------------------------------------------
interface hilo_unit_if;
    logic        MulStart;
    logic [63:0] ALU64Result;
    logic        MoveHi;
    logic        MoveLo;
    logic [31:0] MoveData;
    logic        ReadReq;
    logic [63:0] HiLo;
    logic        Busy;
    logic        Stall;

    modport master (
        output MulStart, ALU64Result, MoveHi, MoveLo, MoveData, ReadReq,
        input  HiLo, Busy, Stall
    );

    modport slave (
        input  MulStart, ALU64Result, MoveHi, MoveLo, MoveData, ReadReq,
        output HiLo, Busy, Stall
    );
endinterface

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
// Hi/Lo register pair with a fixed-latency commit path for 64-bit results.
// A 64-bit result issued in IDLE is held in a pending register and written to
// {Hi,Lo} exactly MUL_LAT edges after the issue edge. While a result is pending
// any request touching Hi/Lo is stalled and ignored; upstream re-presents it.
// Ports:
//   Clk   : rising-edge clock
//   Reset : synchronous active-high reset
//   bus   : hilo_unit_if.slave (requests in, HiLo/Busy/Stall out)
// Parameter:
//   MUL_LAT : edges from issue to commit, 1..15
// -----------------------------------------------------------------------------
module hilo_unit #(
    parameter int MUL_LAT = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    hilo_unit_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter starts at MUL_LAT-1 so the commit lands on the MUL_LAT-th edge.
    localparam logic [3:0] CntInit = 4'(MUL_LAT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [63:0] pend_q;
    logic [63:0] hilo_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 64'd0;
            hilo_q  <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A 64-bit issue wins; moves in the same cycle are dropped.
                    if (bus.MulStart) begin
                        pend_q  <= bus.ALU64Result;
                        cnt_q   <= CntInit;
                        state_q <= BUSY;
                    end else begin
                        if (bus.MoveHi) hilo_q[63:32] <= bus.MoveData;
                        if (bus.MoveLo) hilo_q[31:0]  <= bus.MoveData;
                    end
                end
                BUSY: begin
                    // Requests are ignored here, including on the commit edge.
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        hilo_q  <= pend_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.HiLo  = hilo_q;
    assign bus.Busy  = (state_q == BUSY);
    assign bus.Stall = (state_q == BUSY) &
                       (bus.MulStart | bus.MoveHi | bus.MoveLo | bus.ReadReq);

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
// Drives two hilo_unit instances (MUL_LAT=4 and MUL_LAT=1) with the same
// directed stimulus. A deadline-based model predicts HiLo/Busy/Stall for each,
// a negedge process compares every cycle, and directed literal checks pin the
// model against hand-computed values.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    // Shared stimulus
    logic        ms  = 1'b0;
    logic [63:0] alu = 64'd0;
    logic        mh  = 1'b0;
    logic        ml  = 1'b0;
    logic [31:0] md  = 32'd0;
    logic        rr  = 1'b0;

    hilo_unit_if bus4 ();
    hilo_unit_if bus1 ();

    assign bus4.MulStart = ms;  assign bus1.MulStart = ms;
    assign bus4.ALU64Result = alu; assign bus1.ALU64Result = alu;
    assign bus4.MoveHi = mh;    assign bus1.MoveHi = mh;
    assign bus4.MoveLo = ml;    assign bus1.MoveLo = ml;
    assign bus4.MoveData = md;  assign bus1.MoveData = md;
    assign bus4.ReadReq = rr;   assign bus1.ReadReq = rr;

    hilo_unit #(.MUL_LAT(4)) dut4 (.Clk(Clk), .Reset(Reset), .bus(bus4));
    hilo_unit #(.MUL_LAT(1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Model: a pending result is a value plus the edge number on which it commits.
    int          lat   [2] = '{4, 1};
    logic [63:0] m_hilo[2];
    logic [63:0] m_pend[2];
    logic        m_busy[2];
    int          m_due [2];
    int          ecnt = 0;

    always @(posedge Clk) begin
        ecnt <= ecnt + 1;
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                m_hilo[i] <= 64'd0;
                m_busy[i] <= 1'b0;
            end else if (m_busy[i]) begin
                if (ecnt == m_due[i]) begin
                    m_hilo[i] <= m_pend[i];
                    m_busy[i] <= 1'b0;
                end
            end else if (ms) begin
                m_pend[i] <= alu;
                m_due[i]  <= ecnt + lat[i];
                m_busy[i] <= 1'b1;
            end else begin
                if (mh) m_hilo[i][63:32] <= md;
                if (ml) m_hilo[i][31:0]  <= md;
            end
        end
    end

    // Per-cycle compare
    always @(negedge Clk) begin
        if (chk_en) begin
            check("L4.HiLo",  bus4.HiLo, m_hilo[0]);
            check("L4.Busy",  64'(bus4.Busy), 64'(m_busy[0]));
            check("L4.Stall", 64'(bus4.Stall), 64'(m_busy[0] & (ms | mh | ml | rr)));
            check("L1.HiLo",  bus1.HiLo, m_hilo[1]);
            check("L1.Busy",  64'(bus1.Busy), 64'(m_busy[1]));
            check("L1.Stall", 64'(bus1.Stall), 64'(m_busy[1] & (ms | mh | ml | rr)));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // Reset
        Reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst.HiLo", bus4.HiLo, 64'd0);
        check("rst.Busy", 64'(bus4.Busy), 64'd0);
        check("rst.Stall", 64'(bus4.Stall), 64'd0);

        // 64-bit issue, commit after 4 edges
        ms = 1'b1; alu = 64'h0000_0001_FFFF_FFFE;
        tick();
        ms = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("mul.Busy", 64'(bus4.Busy), 64'd1);
            check("mul.HiLoHeld", bus4.HiLo, 64'd0);
            tick();
        end
        check("mul.HiLo", bus4.HiLo, 64'h0000_0001_FFFF_FFFE);
        check("mul.BusyLow", 64'(bus4.Busy), 64'd0);

        // ReadReq held during BUSY
        ms = 1'b1; alu = 64'h0000_0000_0000_1234;
        tick();
        ms = 1'b0; rr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rd.Stall", 64'(bus4.Stall), 64'd1);
            tick();
        end
        check("rd.StallIdle", 64'(bus4.Stall), 64'd0);
        check("rd.HiLo", bus4.HiLo, 64'h0000_0000_0000_1234);
        rr = 1'b0;

        // MTHI then MTLO, then both at once
        mh = 1'b1; md = 32'hDEAD_BEEF;
        tick();
        mh = 1'b0; ml = 1'b1; md = 32'h1234_5678;
        tick();
        ml = 1'b0;
        check("mv.HiLo", bus4.HiLo, 64'hDEAD_BEEF_1234_5678);
        mh = 1'b1; ml = 1'b1; md = 32'hA5A5_5A5A;
        tick();
        mh = 1'b0; ml = 1'b0;
        check("mv.Both", bus4.HiLo, 64'hA5A5_5A5A_A5A5_5A5A);

        // Issue beats a same-cycle move; moves during BUSY are ignored
        ms = 1'b1; alu = 64'h5; ml = 1'b1; md = 32'h9;
        tick();
        ms = 1'b0; ml = 1'b0;
        check("pri.Dropped", bus4.HiLo, 64'hA5A5_5A5A_A5A5_5A5A);
        mh = 1'b1; md = 32'hFFFF_FFFF;
        tick(); tick(); tick();
        check("pri.Stall", 64'(bus4.Stall), 64'd1);
        tick();
        check("pri.HiLo", bus4.HiLo, 64'h5);
        mh = 1'b0;
        tick();

        // Reset during BUSY discards the pending value
        ms = 1'b1; alu = 64'hAAAA;
        tick();
        ms = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rb.HiLo", bus4.HiLo, 64'd0);
        check("rb.Busy", 64'(bus4.Busy), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rb.HiLoStays", bus4.HiLo, 64'd0);
        end

        // First issue after reset is accepted
        ms = 1'b1; alu = 64'h77;
        tick();
        ms = 1'b0;
        tick(); tick(); tick(); tick();
        check("post.HiLo", bus4.HiLo, 64'h77);

        // MUL_LAT=1 back-to-back issues
        ms = 1'b1; alu = 64'h1;
        tick();
        alu = 64'h2;
        check("b2b.Stall", 64'(bus1.Stall), 64'd1);
        tick();
        check("b2b.First", bus1.HiLo, 64'h1);
        check("b2b.NoStall", 64'(bus1.Stall), 64'd0);
        tick();
        ms = 1'b0;
        check("b2b.Busy", 64'(bus1.Busy), 64'd1);
        tick();
        check("b2b.Second", bus1.HiLo, 64'h2);

        // Drain
        for (int i = 0; i < 6; i++) tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
